// File: rtl/rw_cmd_ctrl.sv
// rw_cmd_ctrl: RAMWorks bank/capacity-mask registers for the RAM2E SDRAM datapath.
//   Decodes the unlock sequence 00 FF 55 AA C1 AD <cmd> <arg> written to the bank
//   register, and sequences the UFM erase/program handshake that saves the mask.
// Optional feature: define RW_CMD_BITBANG_EN to decode command A8 (bitbang write).
//   Without it, A8 is an unknown command and BBStrobe/BBData are tied low.
// Ports:
//   C14M          clock (14.318 MHz); nRST synchronous active-low reset
//   BankWr/BankD  bank register write strobe and data
//   InitMask/InitMaskVld  mask byte loaded from UFM at init
//   SectorFull    UFM sector full: erase before program
//   UFMBusy/RTPBusy  async UFM busy inputs (2-flop synchronised)
//   RWBank/RWMask current bank and capacity mask
//   DoutSubstUFM  substitute UFM data on next read
//   BBStrobe/BBData  bitbang pulse and bits {DRShift,DRDIn,DRCLK,ARShift,ARDIn,ARCLK}
//   UFMErase/UFMProgram  UFM requests; UFMErr sticky ack timeout
//   SeqState      unlock sequence state (debug)
module rw_cmd_ctrl #(
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO     = 16'hFFFF,
  parameter int unsigned      ACK_TMO = 255
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic       BankWr,
  input  logic [7:0] BankD,
  input  logic [7:0] InitMask,
  input  logic       InitMaskVld,
  input  logic       SectorFull,
  input  logic       UFMBusy,
  input  logic       RTPBusy,
  output logic [7:0] RWBank,
  output logic [7:0] RWMask,
  output logic       DoutSubstUFM,
  output logic       BBStrobe,
  output logic [5:0] BBData,
  output logic       UFMErase,
  output logic       UFMProgram,
  output logic       UFMErr,
  output logic [2:0] SeqState
);

  localparam int unsigned ACKW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

  typedef enum logic [2:0] {
    SQ_00, SQ_FF, SQ_55, SQ_AA, SQ_C1, SQ_AD, SQ_CMD, SQ_ARG
  } seq_t;

  typedef enum logic [2:0] {
    P_IDLE, P_WAITFREE, P_ER, P_ERW, P_PG, P_PGW
  } prog_t;

  seq_t             seq;
  prog_t            pst;
  logic [TMO_W-1:0] tmo_cnt;
  logic [ACKW-1:0]  ack_cnt;
  logic [7:0]       expect_b;
  logic             seq_expire;
  logic             arm_mask;
  logic             prog_req;
  logic             erase_done;
  logic             ubusy_s1, ubusy_s, rbusy_s1, rbusy_s;

  assign SeqState = seq;

  always_comb begin
    expect_b = 8'h00;
    case (seq)
      SQ_00:   expect_b = 8'h00;
      SQ_FF:   expect_b = 8'hFF;
      SQ_55:   expect_b = 8'h55;
      SQ_AA:   expect_b = 8'hAA;
      SQ_C1:   expect_b = 8'hC1;
      SQ_AD:   expect_b = 8'hAD;
      default: expect_b = 8'h00;
    endcase
  end

  // A BankWr on the expiry cycle takes precedence over the timeout.
  assign seq_expire = !BankWr && (seq != SQ_00) && (tmo_cnt == TMO - 1'b1);

  always_ff @(posedge C14M) begin
    if (!nRST) begin
      ubusy_s1 <= 1'b0;
      ubusy_s  <= 1'b0;
      rbusy_s1 <= 1'b0;
      rbusy_s  <= 1'b0;
    end else begin
      ubusy_s1 <= UFMBusy;
      ubusy_s  <= ubusy_s1;
      rbusy_s1 <= RTPBusy;
      rbusy_s  <= rbusy_s1;
    end
  end

  always_ff @(posedge C14M) begin
    if (!nRST) begin
      seq          <= SQ_00;
      tmo_cnt      <= '0;
      arm_mask     <= 1'b0;
      prog_req     <= 1'b0;
      DoutSubstUFM <= 1'b0;
      RWBank       <= '0;
      RWMask       <= '0;
    end else begin
      prog_req <= 1'b0;
      if (InitMaskVld)
        RWMask <= (InitMask == 8'h80) ? 8'hFF : InitMask;
      if (BankWr) begin
        RWBank  <= BankD & ~RWMask;
        tmo_cnt <= '0;
        if (seq != SQ_CMD)
          DoutSubstUFM <= 1'b0;
        case (seq)
          SQ_CMD: begin
            seq <= SQ_ARG;
            case (BankD)
              8'h57:   prog_req     <= 1'b1;
              8'hA3:   DoutSubstUFM <= 1'b1;
              8'hA0:   arm_mask     <= 1'b1;
              default: ;
            endcase
          end
          SQ_ARG: begin
            seq      <= SQ_00;
            arm_mask <= 1'b0;
            // Later assignment overrides the InitMaskVld load above.
            if (arm_mask)
              RWMask <= BankD;
          end
          default: begin
            if (BankD == expect_b)
              seq <= seq_t'(seq + 3'd1);
            else if (BankD == 8'h00)
              seq <= SQ_FF;
            else
              seq <= SQ_00;
          end
        endcase
      end else if (seq_expire) begin
        seq      <= SQ_00;
        tmo_cnt  <= '0;
        arm_mask <= 1'b0;
      end else if (seq != SQ_00) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

`ifdef RW_CMD_BITBANG_EN
  logic arm_bb;

  always_ff @(posedge C14M) begin
    if (!nRST) begin
      arm_bb   <= 1'b0;
      BBStrobe <= 1'b0;
      BBData   <= '0;
    end else begin
      BBStrobe <= 1'b0;
      if (BankWr && seq == SQ_CMD && BankD == 8'hA8) begin
        arm_bb <= 1'b1;
      end else if (BankWr && seq == SQ_ARG) begin
        arm_bb <= 1'b0;
        if (arm_bb) begin
          BBStrobe <= 1'b1;
          BBData   <= BankD[5:0];
        end
      end else if (seq_expire) begin
        arm_bb <= 1'b0;
      end
    end
  end
`else
  assign BBStrobe = 1'b0;
  assign BBData   = '0;
`endif

  always_ff @(posedge C14M) begin
    if (!nRST) begin
      pst        <= P_IDLE;
      ack_cnt    <= '0;
      erase_done <= 1'b0;
      UFMErase   <= 1'b0;
      UFMProgram <= 1'b0;
      UFMErr     <= 1'b0;
    end else begin
      case (pst)
        P_IDLE: begin
          if (prog_req) begin
            pst        <= P_WAITFREE;
            erase_done <= 1'b0;
          end
        end
        P_WAITFREE: begin
          if (!ubusy_s && !rbusy_s) begin
            ack_cnt <= '0;
            if (SectorFull && !erase_done) begin
              pst      <= P_ER;
              UFMErase <= 1'b1;
            end else begin
              pst        <= P_PG;
              UFMProgram <= 1'b1;
            end
          end
        end
        P_ER: begin
          if (ubusy_s) begin
            pst      <= P_ERW;
            UFMErase <= 1'b0;
          end else if (ack_cnt == ACKW'(ACK_TMO - 1)) begin
            pst      <= P_IDLE;
            UFMErase <= 1'b0;
            UFMErr   <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        P_ERW: begin
          if (!ubusy_s) begin
            pst        <= P_WAITFREE;
            erase_done <= 1'b1;
          end
        end
        P_PG: begin
          if (ubusy_s) begin
            pst        <= P_PGW;
            UFMProgram <= 1'b0;
          end else if (ack_cnt == ACKW'(ACK_TMO - 1)) begin
            pst        <= P_IDLE;
            UFMProgram <= 1'b0;
            UFMErr     <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        P_PGW: begin
          if (!ubusy_s)
            pst <= P_IDLE;
        end
        default: pst <= P_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rw_cmd_ctrl.md
Name:
rw_cmd_ctrl

Overview:
- Owns the RAMWorks bank and capacity-mask registers for the RAM2E SDRAM datapath.
- Decodes the magic unlock sequence written to the bank register: 00 FF 55 AA C1 AD, then a command byte, then an argument write.
- Sequences the UFM erase/program handshake that saves the capacity mask.
- Sits between the bus-cycle sequencer, which supplies bank-register write strobes, and the SDRAM/UFM primitives, which consume RWBank, RWMask and the UFM control lines.

Parameters:
- TMO_W, 16: width of the sequence-idle timeout counter.
- TMO, 16'hFFFF: idle C14M cycles with no BankWr before the sequence resets to state 0.
- ACK_TMO, 255: max cycles waiting for UFMBusy to rise after Erase/Program is asserted.

Ports:
- C14M  in  1  system clock, 14.318 MHz
- nRST  in  1  synchronous active-low reset
- BankWr  in  1  one-cycle strobe: bank register written this cycle
- BankD  in  8  data byte qualified by BankWr
- InitMask  in  8  mask byte read from UFM at init
- InitMaskVld  in  1  one-cycle strobe qualifying InitMask
- SectorFull  in  1  level: UFM sector full, erase required before program
- UFMBusy  in  1  async UFM busy
- RTPBusy  in  1  async UFM real-time-programming busy
- RWBank  out  8  current RAMWorks bank
- RWMask  out  8  capacity mask
- DoutSubstUFM  out  1  substitute UFM data on next read
- BBStrobe  out  1  bitbang write pulse
- BBData  out  6  bitbang bits {DRShift,DRDIn,DRCLK,ARShift,ARDIn,ARCLK}
- UFMErase  out  1  UFM erase request
- UFMProgram  out  1  UFM program request
- UFMErr  out  1  sticky: handshake ack timeout
- SeqState  out  3  sequence state, debug

Behaviour:
- Clock and reset: all state is on the rising edge of C14M. nRST low at an edge forces every output and register to 0, including mid-handshake; Erase/Program drop the next cycle.
- Busy synchronisers: UFMBusy and RTPBusy pass through 2-flop synchronisers. All decisions use the synced copies, so there are 2 cycles of input latency.
- Bank register: every BankWr loads RWBank <= BankD & ~RWMask, using the pre-edge RWMask, 1-cycle latency.
- Init mask: InitMaskVld loads RWMask <= (InitMask==8'h80) ? 8'hFF : InitMask.
- Sequence FSM (SeqState 0..7), advancing only on BankWr:
  - States 0..5 expect 00, FF, 55, AA, C1, AD respectively. Match -> state+1.
  - Mismatch -> state 1 if BankD==00, else state 0.
  - State 6: latch command byte, go to 7.
    - 57 -> ProgReq.
    - A3 -> DoutSubstUFM=1.
    - A8 -> bitbang armed.
    - A0 -> mask-set armed.
    - Any other byte -> no action.
  - State 7: execute the armed action, clear the arm flags, go to 0.
    - Mask-set: RWMask <= BankD.
    - Bitbang: BBData <= BankD[5:0], BBStrobe=1 for exactly 1 cycle.
  - DoutSubstUFM clears on any BankWr not in state 6.
- Sequence idle timeout: counter counts C14M cycles while SeqState!=0 and reloads on BankWr. On reaching TMO, SeqState <= 0 and arm flags clear. If BankWr and expiry coincide, BankWr wins.
- Same-cycle priority: mask-set write in state 7 beats InitMaskVld.
- Program FSM states: IDLE, WAITFREE, ER, ERW, PG, PGW.
  - IDLE: ProgReq -> WAITFREE. ProgReq is ignored when not IDLE.
  - WAITFREE: when synced UFMBusy=0 and RTPBusy=0 -> ER if SectorFull, else PG.
  - ER: UFMErase=1 until synced UFMBusy=1 -> ERW.
  - ERW: Erase=0, wait UFMBusy=0 -> WAITFREE, with the erase-done flag forcing PG next.
  - PG: UFMProgram=1 until UFMBusy=1 -> PGW.
  - PGW: wait UFMBusy=0 -> IDLE.
  - Ack timeout: no UFMBusy rise within ACK_TMO cycles in ER or PG -> drop the request, set UFMErr (cleared only by reset), return to IDLE.

Optional Feature:
- RW_CMD_BITBANG_EN defined: command A8 is decoded, and BBStrobe/BBData operate as described.
- Undefined: A8 is treated as an unknown command (sequence still steps 6->7->0), BBStrobe and BBData are tied to 0, and the bitbang logic is removed.

Test Plan:
- Reset, then InitMaskVld with InitMask=80 -> RWMask=FF; BankWr BankD=3C -> RWBank=00.
- Write 00 FF 55 AA C1 AD A0 0F -> RWMask=0F, SeqState=0; then BankWr F5 -> RWBank=F0.
- Write 00 FF 55 12 -> SeqState=0; then 00 FF 00 -> SeqState=1, which checks the restart-on-00 case.
- Write 00 FF 55 with TMO=16 and 16 idle cycles -> SeqState=0; same sequence with BankWr on the expiry cycle -> the write is evaluated and the timer reloads.
- Command 57 with SectorFull=1 and a busy model responding after 3 cycles -> UFMErase pulse, then UFMProgram, final IDLE, UFMErr=0; repeat with the model never responding -> UFMErr=1 after ACK_TMO.
- With RW_CMD_BITBANG_EN defined: unlock, A8, 2A -> BBStrobe high 1 cycle, BBData=2A; without the macro -> BBStrobe stays 0.
